// File: rtl/zube_z80_bus.sv
// Z80 I/O bus slave: synchronises the bus strobes, filters glitches and
// decodes four ports into register write pulses and read strobes.
module zube_z80_bus #(
    parameter logic [7:0] BASE_PORT = 8'h80,
    parameter int         FILTER    = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [27:0] io_in,
    output logic [27:0] io_out,
    output logic [27:0] io_oeb,
    output logic [1:0]  reg_addr,
    output logic        wr_valid,
    output logic [7:0]  wr_data,
    output logic        rd_strobe,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_FETCH,
        S_READ_DRIVE,
        S_HOLD
    } state_t;

    localparam logic [2:0] FILT = FILTER[2:0];

    // strobe vector order: {M1_b, WR_b, RD_b, IORQ_b}
    logic [3:0]  ctl_s1_q, ctl_s2_q;
    logic [15:0] ad_q;
    logic [2:0]  cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  drive_q, drive_d;

    logic iorq_b, rd_b, wr_b, m1_b;
    logic qual, driving;

    // upper GPIO pins are not part of the bus
    logic unused_pins;
    assign unused_pins = ^io_in[27:20];

    assign iorq_b = ctl_s2_q[0];
    assign rd_b   = ctl_s2_q[1];
    assign wr_b   = ctl_s2_q[2];
    assign m1_b   = ctl_s2_q[3];

    // a decodable I/O cycle: not an interrupt ack, exactly one of RD/WR
    assign qual = !iorq_b && m1_b && (rd_b ^ wr_b)
                  && (ad_q[15:10] == BASE_PORT[7:2]);

    // two-flop strobe synchroniser (idle high) and one-stage A/D capture
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ctl_s1_q <= 4'hF;
            ctl_s2_q <= 4'hF;
            ad_q     <= 16'h0000;
        end else begin
            ctl_s1_q <= io_in[19:16];
            ctl_s2_q <= ctl_s1_q;
            ad_q     <= io_in[15:0];
        end
    end

    // glitch filter: count consecutive qualified samples, saturating
    always_comb begin
        cnt_d = 3'd0;
        if (qual) begin
            cnt_d = (cnt_q >= FILT) ? cnt_q : cnt_q + 3'd1;
        end
    end

    // FSM state, filter counter, latches and read drive register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 2'd0;
            wdata_q <= 8'h00;
            drive_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drive_q <= drive_d;
        end
    end

    // next-state: accept once filtered, then wait for the bus to go idle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        drive_d = drive_q;
        unique case (state_q)
            S_IDLE: begin
                if (qual && (cnt_d == FILT)) begin
                    addr_d = ad_q[9:8];
                    if (!wr_b) begin
                        wdata_d = ad_q[7:0];
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ_FETCH;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_HOLD;
            end
            S_READ_FETCH: begin
                drive_d = rd_data;
                state_d = S_READ_DRIVE;
            end
            S_READ_DRIVE: begin
                if (rd_b || iorq_b) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (iorq_b && rd_b && wr_b) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // outputs decode from the state register so reset releases D at once
    assign driving   = (state_q == S_READ_DRIVE);
    assign io_out    = {20'h00000, driving ? drive_q : 8'h00};
    assign io_oeb    = {20'hFFFFF, driving ? 8'h00 : 8'hFF};
    assign reg_addr  = addr_q;
    assign wr_data   = wdata_q;
    assign wr_valid  = (state_q == S_WRITE);
    assign rd_strobe = (state_q == S_READ_FETCH);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_zube_z80_bus.sv
// Randomised bench for zube_z80_bus: bus cycles of random kind, port and
// strobe length checked against a cycle-count model of the bus rules.
module tb_zube_z80_bus;

    localparam int         FILT = 2;
    localparam logic [7:0] BASE = 8'h80;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [27:0] io_in;
    logic [27:0] io_out;
    logic [27:0] io_oeb;
    logic [1:0]  reg_addr;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        rd_strobe;
    logic [7:0]  rd_data;
    logic        busy;

    logic [7:0] a_bus, d_bus;
    logic       iorq_b, rd_b, wr_b, m1_b;

    assign io_in = {8'h00, m1_b, wr_b, rd_b, iorq_b, a_bus, d_bus};

    zube_z80_bus #(.BASE_PORT(BASE), .FILTER(FILT)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .reg_addr (reg_addr),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .rd_strobe(rd_strobe),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observed events, sampled on the falling edge
    int         n_wr, n_rd, n_drv, n_bad;
    logic [1:0] wr_addr, rd_addr;
    logic [7:0] wr_dat, drv_dat;

    always @(negedge clk) begin
        if (wr_valid) begin
            n_wr++;
            wr_addr = reg_addr;
            wr_dat  = wr_data;
        end
        if (rd_strobe) begin
            n_rd++;
            rd_addr = reg_addr;
        end
        if (io_oeb[7:0] == 8'h00) begin
            n_drv++;
            drv_dat = io_out[7:0];
        end
        if (io_oeb[27:8] != 20'hFFFFF || io_out[27:8] != 20'h0
            || (io_oeb[7:0] != 8'h00 && io_oeb[7:0] != 8'hFF))
            n_bad++;
    end

    task automatic clear_obs();
        n_wr = 0; n_rd = 0; n_drv = 0; n_bad = 0;
    endtask

    task automatic bus_idle();
        iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    endtask

    // kind: 0 write, 1 read, 2 interrupt ack, 3 RD and WR both low
    task automatic bus_cycle(input int kind, input logic [7:0] port,
                             input logic [7:0] data, input int len);
        bit hit, acc;
        int exp_wr, exp_rd, exp_drv;
        a_bus = port; d_bus = data; rd_data = data;
        repeat (3) @(negedge clk);
        #1;
        clear_obs();
        iorq_b = 1'b0;
        case (kind)
            0: wr_b = 1'b0;
            1: rd_b = 1'b0;
            2: begin rd_b = 1'b0; m1_b = 1'b0; end
            default: begin rd_b = 1'b0; wr_b = 1'b0; end
        endcase
        repeat (len) @(negedge clk);
        #1;
        bus_idle();
        repeat (10) @(negedge clk);
        #1;
        hit = (port[7:2] == BASE[7:2]) && (kind == 0 || kind == 1);
        acc = hit && (len >= FILT);
        exp_wr  = (acc && kind == 0) ? 1 : 0;
        exp_rd  = (acc && kind == 1) ? 1 : 0;
        exp_drv = 0;
        if (exp_rd == 1) exp_drv = (len - FILT > 1) ? len - FILT : 1;
        check("wr_pulses", 32'(n_wr), 32'(exp_wr));
        check("rd_pulses", 32'(n_rd), 32'(exp_rd));
        check("drive_cycles", 32'(n_drv), 32'(exp_drv));
        check("pin_rules", 32'(n_bad), 0);
        check("busy_after", 32'(busy), 0);
        if (exp_wr == 1) begin
            check("wr_addr", 32'(wr_addr), 32'(port[1:0]));
            check("wr_data", 32'(wr_dat), 32'(data));
        end
        if (exp_rd == 1) begin
            check("rd_addr", 32'(rd_addr), 32'(port[1:0]));
            check("rd_drive", 32'(drv_dat), 32'(data));
        end
    endtask

    initial begin
        int  k, len;
        bit  seen;
        logic [7:0] p;
        reset_b = 1'b0;
        bus_idle();
        a_bus = 8'h00; d_bus = 8'h00; rd_data = 8'h00;
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_oeb", 32'(io_oeb), 32'h0FFFFFFF);
        check("rst_out", 32'(io_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_rd_strobe", 32'(rd_strobe), 0);
        check("rst_addr", 32'(reg_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        #1 reset_b = 1'b1;

        bus_cycle(0, 8'h82, 8'h5A, 10);
        bus_cycle(1, 8'h81, 8'hC3, 10);
        bus_cycle(0, 8'h80, 8'h11, 1);
        bus_cycle(1, 8'h80, 8'h12, 1);
        bus_cycle(2, 8'h80, 8'h22, 6);
        bus_cycle(1, 8'h40, 8'h33, 6);
        bus_cycle(3, 8'h83, 8'h44, 6);
        bus_cycle(1, 8'h83, 8'h77, 2);
        bus_cycle(0, 8'h83, 8'h78, 2);

        // long write, then strobes released one at a time
        a_bus = 8'h81; d_bus = 8'hA5;
        repeat (3) @(negedge clk);
        #1;
        clear_obs();
        iorq_b = 1'b0; wr_b = 1'b0;
        repeat (50) @(negedge clk);
        check("long_wr_pulses", 32'(n_wr), 1);
        check("long_wr_data", 32'(wr_dat), 32'h A5);
        check("long_busy", 32'(busy), 1);
        #1 wr_b = 1'b1;
        repeat (6) @(negedge clk);
        check("hold_iorq_low", 32'(busy), 1);
        #1 iorq_b = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_exit", 32'(busy), 0);
        check("long_wr_once", 32'(n_wr), 1);
        bus_cycle(0, 8'h81, 8'h5C, 8);

        for (int i = 0; i < 60; i++) begin
            k   = $urandom_range(0, 5);
            if (k > 3) k = k - 4;
            p   = 8'($urandom);
            if ($urandom_range(0, 3) != 0) p = {BASE[7:2], p[1:0]};
            len = $urandom_range(1, 12);
            bus_cycle(k, p, 8'($urandom), len);
        end

        // reset mid-drive releases D without a clock edge
        a_bus = 8'h82; rd_data = 8'h99;
        repeat (3) @(negedge clk);
        #1;
        iorq_b = 1'b0; rd_b = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (io_oeb[7:0] == 8'h00) seen = 1'b1;
        end
        check("drive_seen", 32'(seen), 1);
        #2 reset_b = 1'b0;
        #1;
        check("async_oeb", 32'(io_oeb), 32'h0FFFFFFF);
        check("async_busy", 32'(busy), 0);
        check("async_out", 32'(io_out), 0);
        clear_obs();
        @(negedge clk);
        #1 reset_b = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_rd", 32'(n_rd), 1);
        check("post_rst_drive", 32'(drv_dat), 32'h99);
        #1 bus_idle();
        repeat (8) @(negedge clk);
        check("post_rst_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
